upgrade_armor_mgr: RTL and testbench

- Next-generation armor power-up controller for N players, clocked once per video frame.
- Owns the armor item's full life cycle: available on the field, collected, attached to the owner's rear, absorbing rear hits, expiring, then respawning after a delay.
- Drives the armor sprite's position and size to the color mapper, and reports an absorbed-hit pulse to the hit-resolution logic.

---
 rtl/game_pkg.sv | 26 ++
 rtl/box_hit_detect.sv | 32 +++
 rtl/upgrade_armor_mgr.sv | 225 ++++++++++++++++++++++
 tb/tb_upgrade_armor_mgr.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared types and constants for the tank game video/logic blocks.
//   dir_e          : tank facing direction as encoded on Player_Dir
//   armor_state_e  : life-cycle state of the armor power-up
//   SCREEN_W/H     : visible frame size in pixels, used for position clamping
// -----------------------------------------------------------------------------
package game_pkg;

   localparam int SCREEN_W = 640;
   localparam int SCREEN_H = 480;

   typedef enum logic [1:0] {
      DIR_LEFT  = 2'b00,
      DIR_RIGHT = 2'b01,
      DIR_DOWN  = 2'b10,
      DIR_UP    = 2'b11
   } dir_e;

   typedef enum logic [1:0] {
      ARMOR_AVAILABLE    = 2'd0,
      ARMOR_ATTACHED     = 2'd1,
      ARMOR_RESPAWN_WAIT = 2'd2
   } armor_state_e;

endpackage

// File: rtl/box_hit_detect.sv
// -----------------------------------------------------------------------------
// box_hit_detect
// Combinational point-in-box test, inclusive on all four edges.
// Ports:
//   PointX, PointY  in  10  point to test (e.g. a player centre)
//   BoxX, BoxY      in  10  box centre
//   Box_Size        in  10  box half-size
//   hit             out  1  point lies inside [Box-Size, Box+Size] on both axes
// The lower bound saturates at 0 and the compare runs in 11 bits, so a box near
// the top/left screen edge never wraps around to a huge bound.
// -----------------------------------------------------------------------------
module box_hit_detect (
   input  logic [9:0] PointX,
   input  logic [9:0] PointY,
   input  logic [9:0] BoxX,
   input  logic [9:0] BoxY,
   input  logic [9:0] Box_Size,
   output logic       hit
);

   logic [10:0] x_lo, x_hi, y_lo, y_hi;

   always_comb begin
      x_lo = (BoxX >= Box_Size) ? ({1'b0, BoxX} - {1'b0, Box_Size}) : 11'd0;
      y_lo = (BoxY >= Box_Size) ? ({1'b0, BoxY} - {1'b0, Box_Size}) : 11'd0;
      x_hi = {1'b0, BoxX} + {1'b0, Box_Size};
      y_hi = {1'b0, BoxY} + {1'b0, Box_Size};
      hit  = ({1'b0, PointX} >= x_lo) && ({1'b0, PointX} <= x_hi) &&
             ({1'b0, PointY} >= y_lo) && ({1'b0, PointY} <= y_hi);
   end

endmodule

// File: rtl/upgrade_armor_mgr.sv
// -----------------------------------------------------------------------------
// upgrade_armor_mgr
// Armor power-up controller, clocked once per video frame. Owns the armor's
// life cycle: available on the field -> attached to the collector's rear
// (absorbing rear hits) -> respawn wait -> available again.
// Ports:
//   frame_clk            in   1           frame clock
//   Reset_n              in   1           asynchronous active-low reset
//   PlayerX, PlayerY     in   N*10        packed player centres, player i at [10i+9:10i]
//   Player_Size          in   10          player half-size
//   Player_Dir           in   N*2         packed facing direction (dir_e)
//   Rear_Hit             in   N           1-frame pulse: player i struck from behind
//   UpgradeX/Y/_Size     in   10 each     spawn-point centre and half-size
//   ArmorX, ArmorY       out  10 each     armor sprite centre
//   Armor_Length_Halved  out  10          sprite half-width
//   Armor_Height_Halved  out  10          sprite half-height
//   armor_visible        out  1           draw enable
//   armor_owner          out  N           one-hot owner, 0 when unowned
//   hits_left            out  4           remaining durability
//   was_collected        out  1           high while attached
//   hit_absorbed         out  N           1-frame pulse: rear hit on player i absorbed
// All outputs are registered and describe the state entered on the same edge.
// -----------------------------------------------------------------------------
module upgrade_armor_mgr
   import game_pkg::*;
#(
   parameter int N_PLAYERS       = 2,
   parameter int ARMOR_LONG      = 12,
   parameter int ARMOR_SHORT     = 4,
   parameter int ARMOR_GAP       = 10,
   parameter int ARMOR_HITS      = 3,
   parameter int LIFETIME_FRAMES = 600,
   parameter int RESPAWN_FRAMES  = 300
) (
   input  logic                     frame_clk,
   input  logic                     Reset_n,
   input  logic [N_PLAYERS*10-1:0]  PlayerX,
   input  logic [N_PLAYERS*10-1:0]  PlayerY,
   input  logic [9:0]               Player_Size,
   input  logic [N_PLAYERS*2-1:0]   Player_Dir,
   input  logic [N_PLAYERS-1:0]     Rear_Hit,
   input  logic [9:0]               UpgradeX,
   input  logic [9:0]               UpgradeY,
   input  logic [9:0]               Upgrade_Size,
   output logic [9:0]               ArmorX,
   output logic [9:0]               ArmorY,
   output logic [9:0]               Armor_Length_Halved,
   output logic [9:0]               Armor_Height_Halved,
   output logic                     armor_visible,
   output logic [N_PLAYERS-1:0]     armor_owner,
   output logic [3:0]               hits_left,
   output logic                     was_collected,
   output logic [N_PLAYERS-1:0]     hit_absorbed
);

   localparam int MAX_FRAMES = (LIFETIME_FRAMES > RESPAWN_FRAMES) ? LIFETIME_FRAMES : RESPAWN_FRAMES;
   localparam int CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
   localparam logic [CNT_W-1:0] LIFE_LAST    = CNT_W'(LIFETIME_FRAMES - 1);
   localparam logic [CNT_W-1:0] RESPAWN_LAST = CNT_W'(RESPAWN_FRAMES - 1);

   armor_state_e         state;
   logic [CNT_W-1:0]     frame_cnt;   // shared life/respawn counter, cleared on every state change

   logic [N_PLAYERS-1:0] in_box;
   logic [N_PLAYERS-1:0] collect_onehot;
   logic                 collect_any;

   logic [9:0]           own_x, own_y;
   dir_e                 own_dir;
   logic [10:0]          rear_offset;
   logic signed [12:0]   own_x_s, own_y_s, off_s;
   logic [9:0]           rear_x, rear_y, rear_len, rear_ht;
   logic                 owner_hit;

   // Saturate an extended signed coordinate into 0..vmax.
   function automatic logic [9:0] clamp_pos(input logic signed [12:0] v,
                                            input logic signed [12:0] vmax);
      if (v < 13'sd0)
         return 10'd0;
      else if (v > vmax)
         return vmax[9:0];
      else
         return v[9:0];
   endfunction

   for (genvar i = 0; i < N_PLAYERS; i++) begin : g_box
      box_hit_detect u_box (
         .PointX   (PlayerX[10*i +: 10]),
         .PointY   (PlayerY[10*i +: 10]),
         .BoxX     (UpgradeX),
         .BoxY     (UpgradeY),
         .Box_Size (Upgrade_Size),
         .hit      (in_box[i])
      );
   end

   // Lowest-index player wins a simultaneous collection.
   always_comb begin
      collect_onehot = '0;
      collect_any    = 1'b0;
      for (int i = 0; i < N_PLAYERS; i++) begin
         if (in_box[i] && !collect_any) begin
            collect_onehot[i] = 1'b1;
            collect_any       = 1'b1;
         end
      end
   end

   // Rear placement: armor sits behind the owner, opposite to its facing.
   always_comb begin
      own_x   = '0;
      own_y   = '0;
      own_dir = DIR_LEFT;
      for (int i = 0; i < N_PLAYERS; i++) begin
         if (armor_owner[i]) begin
            own_x   = PlayerX[10*i +: 10];
            own_y   = PlayerY[10*i +: 10];
            own_dir = dir_e'(Player_Dir[2*i +: 2]);
         end
      end

      rear_offset = {1'b0, Player_Size} + 11'(ARMOR_GAP);
      own_x_s     = signed'({3'b000, own_x});
      own_y_s     = signed'({3'b000, own_y});
      off_s       = signed'({2'b00, rear_offset});

      rear_x   = own_x;
      rear_y   = own_y;
      rear_len = 10'(ARMOR_SHORT);
      rear_ht  = 10'(ARMOR_LONG);
      case (own_dir)
         DIR_LEFT:  rear_x = clamp_pos(own_x_s + off_s, 13'(SCREEN_W - 1));
         DIR_RIGHT: rear_x = clamp_pos(own_x_s - off_s, 13'(SCREEN_W - 1));
         DIR_DOWN: begin
            rear_y   = clamp_pos(own_y_s - off_s, 13'(SCREEN_H - 1));
            rear_len = 10'(ARMOR_LONG);
            rear_ht  = 10'(ARMOR_SHORT);
         end
         DIR_UP: begin
            rear_y   = clamp_pos(own_y_s + off_s, 13'(SCREEN_H - 1));
            rear_len = 10'(ARMOR_LONG);
            rear_ht  = 10'(ARMOR_SHORT);
         end
         default: ;
      endcase

      owner_hit = |(Rear_Hit & armor_owner);
   end

   always_ff @(posedge frame_clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state               <= ARMOR_AVAILABLE;
         frame_cnt           <= '0;
         armor_owner         <= '0;
         hits_left           <= 4'd0;
         was_collected       <= 1'b0;
         hit_absorbed        <= '0;
         ArmorX              <= 10'd0;
         ArmorY              <= 10'd0;
         Armor_Length_Halved <= 10'd0;
         Armor_Height_Halved <= 10'd0;
         armor_visible       <= 1'b1;
      end else begin
         hit_absorbed <= '0;
         case (state)
            ARMOR_AVAILABLE: begin
               ArmorX              <= UpgradeX;
               ArmorY              <= UpgradeY;
               Armor_Length_Halved <= Upgrade_Size;
               Armor_Height_Halved <= Upgrade_Size;
               armor_visible       <= 1'b1;
               if (collect_any) begin
                  state         <= ARMOR_ATTACHED;
                  armor_owner   <= collect_onehot;
                  hits_left     <= 4'(ARMOR_HITS);
                  frame_cnt     <= '0;
                  was_collected <= 1'b1;
               end
            end

            ARMOR_ATTACHED: begin
               ArmorX              <= rear_x;
               ArmorY              <= rear_y;
               Armor_Length_Halved <= rear_len;
               Armor_Height_Halved <= rear_ht;
               if (owner_hit) begin
                  hit_absorbed <= Rear_Hit & armor_owner;
                  hits_left    <= hits_left - 4'd1;
               end
               // A breaking hit coinciding with expiry is still absorbed above.
               if ((owner_hit && hits_left == 4'd1) || frame_cnt == LIFE_LAST) begin
                  state         <= ARMOR_RESPAWN_WAIT;
                  frame_cnt     <= '0;
                  armor_owner   <= '0;
                  hits_left     <= 4'd0;
                  was_collected <= 1'b0;
                  armor_visible <= 1'b0;
               end else begin
                  frame_cnt <= frame_cnt + 1'b1;
               end
            end

            ARMOR_RESPAWN_WAIT: begin
               if (frame_cnt == RESPAWN_LAST) begin
                  state               <= ARMOR_AVAILABLE;
                  frame_cnt           <= '0;
                  armor_visible       <= 1'b1;
                  ArmorX              <= UpgradeX;
                  ArmorY              <= UpgradeY;
                  Armor_Length_Halved <= Upgrade_Size;
                  Armor_Height_Halved <= Upgrade_Size;
               end else begin
                  frame_cnt <= frame_cnt + 1'b1;
               end
            end

            default: begin
               state     <= ARMOR_AVAILABLE;
               frame_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_upgrade_armor_mgr.sv
// -----------------------------------------------------------------------------
// tb_upgrade_armor_mgr
// Directed bench for upgrade_armor_mgr (2 players, lifetime 5, respawn 3).
// A vector table covers rear placement for every direction and the screen-edge
// clamps; hand-written sequences cover reset, collection priority, durability,
// lifetime/respawn, break-on-expiry, async reset and the saturating box bound.
// -----------------------------------------------------------------------------
module tb_upgrade_armor_mgr;

   logic        frame_clk = 1'b0;
   logic        Reset_n   = 1'b1;
   logic [19:0] PlayerX   = '0;
   logic [19:0] PlayerY   = '0;
   logic [9:0]  Player_Size = 10'd8;
   logic [3:0]  Player_Dir  = '0;
   logic [1:0]  Rear_Hit    = '0;
   logic [9:0]  UpgradeX = 10'd100, UpgradeY = 10'd100, Upgrade_Size = 10'd8;
   logic [9:0]  ArmorX, ArmorY, Armor_Length_Halved, Armor_Height_Halved;
   logic        armor_visible;
   logic [1:0]  armor_owner;
   logic [3:0]  hits_left;
   logic        was_collected;
   logic [1:0]  hit_absorbed;

   int n_tests = 0;
   int n_fail  = 0;

   upgrade_armor_mgr #(
      .N_PLAYERS       (2),
      .ARMOR_LONG      (12),
      .ARMOR_SHORT     (4),
      .ARMOR_GAP       (10),
      .ARMOR_HITS      (3),
      .LIFETIME_FRAMES (5),
      .RESPAWN_FRAMES  (3)
   ) dut (
      .frame_clk           (frame_clk),
      .Reset_n             (Reset_n),
      .PlayerX             (PlayerX),
      .PlayerY             (PlayerY),
      .Player_Size         (Player_Size),
      .Player_Dir          (Player_Dir),
      .Rear_Hit            (Rear_Hit),
      .UpgradeX            (UpgradeX),
      .UpgradeY            (UpgradeY),
      .Upgrade_Size        (Upgrade_Size),
      .ArmorX              (ArmorX),
      .ArmorY              (ArmorY),
      .Armor_Length_Halved (Armor_Length_Halved),
      .Armor_Height_Halved (Armor_Height_Halved),
      .armor_visible       (armor_visible),
      .armor_owner         (armor_owner),
      .hits_left           (hits_left),
      .was_collected       (was_collected),
      .hit_absorbed        (hit_absorbed)
   );

   always #5 frame_clk = ~frame_clk;

   typedef struct {
      logic [9:0] px, py, psize;
      logic [1:0] dir;
      logic [9:0] ex, ey, elen, eht;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge frame_clk);
      #1;
   endtask

   task automatic set_p(input int i, input logic [9:0] x, input logic [9:0] y);
      PlayerX[10*i +: 10] = x;
      PlayerY[10*i +: 10] = y;
   endtask

   task automatic do_reset();
      Reset_n = 1'b0;
      #1;
      Reset_n = 1'b1;
   endtask

   initial begin
      // placement table: offset = psize + 10, clamped to 0..639 / 0..479
      vecs[0] = '{10'd100, 10'd96,  10'd8, 2'b01, 10'd82,  10'd96,  10'd4,  10'd12};
      vecs[1] = '{10'd100, 10'd96,  10'd8, 2'b00, 10'd118, 10'd96,  10'd4,  10'd12};
      vecs[2] = '{10'd200, 10'd150, 10'd5, 2'b10, 10'd200, 10'd135, 10'd12, 10'd4};
      vecs[3] = '{10'd200, 10'd150, 10'd5, 2'b11, 10'd200, 10'd165, 10'd12, 10'd4};
      vecs[4] = '{10'd5,   10'd50,  10'd8, 2'b01, 10'd0,   10'd50,  10'd4,  10'd12};
      vecs[5] = '{10'd635, 10'd50,  10'd8, 2'b00, 10'd639, 10'd50,  10'd4,  10'd12};
      vecs[6] = '{10'd300, 10'd3,   10'd8, 2'b10, 10'd300, 10'd0,   10'd12, 10'd4};
      vecs[7] = '{10'd300, 10'd470, 10'd8, 2'b11, 10'd300, 10'd479, 10'd12, 10'd4};

      set_p(0, 10'd500, 10'd400);
      set_p(1, 10'd600, 10'd420);
      Player_Dir = 4'b0101;

      // reset values
      #1 Reset_n = 1'b0;
      #1;
      chk("rst_owner", armor_owner, 0);
      chk("rst_hits", hits_left, 0);
      chk("rst_collected", was_collected, 0);
      chk("rst_armorx", ArmorX, 0);
      chk("rst_len", Armor_Length_Halved, 0);
      chk("rst_absorbed", hit_absorbed, 0);
      @(negedge frame_clk);
      Reset_n = 1'b1;
      tick();
      chk("avail_x", ArmorX, 100);
      chk("avail_y", ArmorY, 100);
      chk("avail_len", Armor_Length_Halved, 8);
      chk("avail_ht", Armor_Height_Halved, 8);
      chk("avail_vis", armor_visible, 1);
      chk("avail_owner", armor_owner, 0);

      // table: collect at (104,96), then move and check rear placement
      for (int k = 0; k < 8; k++) begin
         do_reset();
         set_p(0, 10'd104, 10'd96);
         set_p(1, 10'd600, 10'd420);
         Player_Size = vecs[k].psize;
         Player_Dir  = {2'b01, vecs[k].dir};
         tick();
         chk($sformatf("vec%0d_owner", k), armor_owner, 1);
         chk($sformatf("vec%0d_hits", k), hits_left, 3);
         chk($sformatf("vec%0d_collected", k), was_collected, 1);
         set_p(0, vecs[k].px, vecs[k].py);
         tick();
         chk($sformatf("vec%0d_x", k), ArmorX, vecs[k].ex);
         chk($sformatf("vec%0d_y", k), ArmorY, vecs[k].ey);
         chk($sformatf("vec%0d_len", k), Armor_Length_Halved, vecs[k].elen);
         chk($sformatf("vec%0d_ht", k), Armor_Height_Halved, vecs[k].eht);
      end

      // just outside the box, then simultaneous collection, then durability
      Player_Size = 10'd8;
      Player_Dir  = 4'b0101;
      do_reset();
      set_p(0, 10'd109, 10'd100);
      set_p(1, 10'd100, 10'd91);
      tick();
      chk("outside_owner", armor_owner, 0);
      set_p(0, 10'd100, 10'd100);
      set_p(1, 10'd100, 10'd100);
      tick();
      chk("simul_owner", armor_owner, 1);
      set_p(0, 10'd300, 10'd200);
      set_p(1, 10'd600, 10'd420);
      Rear_Hit = 2'b10;
      tick();
      chk("nonowner_absorbed", hit_absorbed, 0);
      chk("nonowner_hits", hits_left, 3);
      Rear_Hit = 2'b01;
      tick();
      chk("hit1_absorbed", hit_absorbed, 1);
      chk("hit1_hits", hits_left, 2);
      Rear_Hit = 2'b11;
      tick();
      chk("hit2_absorbed", hit_absorbed, 1);
      chk("hit2_hits", hits_left, 1);
      Rear_Hit = 2'b01;
      tick();
      chk("hit3_absorbed", hit_absorbed, 1);
      chk("hit3_hits", hits_left, 0);
      chk("hit3_owner", armor_owner, 0);
      chk("hit3_vis", armor_visible, 0);
      chk("hit3_collected", was_collected, 0);
      Rear_Hit = 2'b00;
      tick();
      chk("after_absorbed", hit_absorbed, 0);

      // lifetime expiry after 5 attached frames, respawn after 3
      do_reset();
      set_p(0, 10'd104, 10'd96);
      tick();
      chk("life_collect", armor_owner, 1);
      set_p(0, 10'd400, 10'd300);
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk($sformatf("life_frame%0d_owner", k), armor_owner, 1);
      end
      chk("life_x", ArmorX, 382);
      tick();
      chk("expire_owner", armor_owner, 0);
      chk("expire_vis", armor_visible, 0);
      set_p(0, 10'd100, 10'd100);
      tick();
      chk("respawn1_vis", armor_visible, 0);
      tick();
      chk("respawn2_vis", armor_visible, 0);
      chk("respawn2_x_held", ArmorX, 382);
      tick();
      chk("respawn3_vis", armor_visible, 1);
      chk("respawn3_x", ArmorX, 100);
      chk("respawn3_y", ArmorY, 100);
      chk("respawn3_owner", armor_owner, 0);
      tick();
      chk("recollect_owner", armor_owner, 1);

      // breaking hit in the same frame as expiry
      do_reset();
      set_p(0, 10'd104, 10'd96);
      tick();
      set_p(0, 10'd400, 10'd300);
      Rear_Hit = 2'b01;
      tick();
      tick();
      Rear_Hit = 2'b00;
      tick();
      tick();
      chk("brk_pre_hits", hits_left, 1);
      chk("brk_pre_owner", armor_owner, 1);
      Rear_Hit = 2'b01;
      tick();
      chk("brk_absorbed", hit_absorbed, 1);
      chk("brk_owner", armor_owner, 0);
      chk("brk_hits", hits_left, 0);
      Rear_Hit = 2'b00;

      // asynchronous reset while attached
      do_reset();
      set_p(0, 10'd104, 10'd96);
      tick();
      chk("async_pre_collected", was_collected, 1);
      set_p(0, 10'd500, 10'd400);
      @(negedge frame_clk);
      #2;
      Reset_n = 1'b0;
      #1;
      chk("async_owner", armor_owner, 0);
      chk("async_collected", was_collected, 0);
      chk("async_hits", hits_left, 0);
      Reset_n = 1'b1;
      tick();
      chk("async_after_vis", armor_visible, 1);
      chk("async_after_x", ArmorX, 100);
      chk("async_after_owner", armor_owner, 0);

      // lower bound saturates at 0 near the screen corner
      do_reset();
      UpgradeX = 10'd4;
      UpgradeY = 10'd4;
      set_p(0, 10'd0, 10'd0);
      tick();
      chk("sat_owner", armor_owner, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
